// File: rtl/ecall_service_unit_pkg.sv
// Shared definitions for the ecall service unit: service codes, FSM states and
// the fixed register index that read-integer results are written to.
package ecall_service_unit_pkg;

    localparam logic [31:0] SVC_PRINT_INT = 32'd1;
    localparam logic [31:0] SVC_READ_INT  = 32'd5;
    localparam logic [31:0] SVC_EXIT      = 32'd10;

    localparam logic [4:0]  A0_IDX        = 5'd10;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_PRESS = 3'd1,
        WRITEBACK  = 3'd2,
        DONE       = 3'd3,
        HALT       = 3'd4
    } state_t;

endpackage

// File: rtl/ecall_service_unit_debounce.sv
// Confirm-button conditioner: two-flop synchroniser followed by a saturating
// stability counter that only moves the accepted level after a run of samples.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic          level_r;

    // Synchronise the asynchronous button into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive samples disagreeing with the accepted level; any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            level_r <= 1'b0;
        end else if (sync2_r == level_r) begin
            cnt_r   <= '0;
            level_r <= level_r;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r   <= cnt_r;
            level_r <= sync2_r;
        end else begin
            cnt_r   <= cnt_r + CW'(1);
            level_r <= level_r;
        end
    end

    assign btn_level = level_r;

endmodule

// File: rtl/ecall_service_unit.sv
// Environment-call sequencer: freezes the core while servicing print, read and
// exit requests, and overrides the register-file write port for read results.
module ecall_service_unit
    import ecall_service_unit_pkg::*;
#(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ecall,
    input  logic [31:0]         a7_val,
    input  logic [31:0]         a0_val,
    input  logic [SW_WIDTH-1:0] switches,
    input  logic                confirm_btn,
    output logic                stall,
    output logic                rf_wr_en,
    output logic [4:0]          rf_wr_sel,
    output logic [31:0]         rf_wr_data,
    output logic [31:0]         display_value,
    output logic                display_valid,
    output logic                halted
);

    state_t      state_r;
    state_t      next_state_s;
    logic        stall_s;
    logic        do_print_s;
    logic        do_capture_s;
    logic        btn_level_s;
    logic        btn_prev_r;
    logic        btn_rise_s;
    logic [31:0] rf_wr_data_r;
    logic [31:0] display_value_r;
    logic        display_valid_r;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (confirm_btn),
        .btn_level(btn_level_s)
    );

    // A level already high when the read starts has btn_prev_r high too, so it never counts as a press.
    assign btn_rise_s = btn_level_s & ~btn_prev_r;

    // State register and debounced-level history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            btn_prev_r <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            btn_prev_r <= btn_level_s;
        end
    end

    // Next-state decode and stall generation.
    always_comb begin
        next_state_s = state_r;
        stall_s      = 1'b0;
        do_print_s   = 1'b0;
        do_capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = ecall;
                if (ecall) begin
                    if (a7_val == SVC_PRINT_INT) begin
                        do_print_s   = 1'b1;
                        next_state_s = DONE;
                    end else if (a7_val == SVC_READ_INT) begin
                        next_state_s = WAIT_PRESS;
                    end else if (a7_val == SVC_EXIT) begin
                        next_state_s = HALT;
                    end else begin
                        next_state_s = DONE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT_PRESS: begin
                stall_s = 1'b1;
                if (btn_rise_s) begin
                    do_capture_s = 1'b1;
                    next_state_s = WRITEBACK;
                end else begin
                    next_state_s = WAIT_PRESS;
                end
            end
            WRITEBACK: begin
                stall_s      = 1'b1;
                next_state_s = DONE;
            end
            DONE: begin
                stall_s      = 1'b0;
                next_state_s = IDLE;
            end
            HALT: begin
                stall_s      = 1'b1;
                next_state_s = HALT;
            end
            default: begin
                stall_s      = 1'b0;
                next_state_s = IDLE;
            end
        endcase
    end

    // Display and read-result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            display_value_r <= 32'd0;
            display_valid_r <= 1'b0;
            rf_wr_data_r    <= 32'd0;
        end else begin
            if (do_print_s) begin
                display_value_r <= a0_val;
                display_valid_r <= 1'b1;
            end else begin
                display_value_r <= display_value_r;
                display_valid_r <= display_valid_r;
            end
            if (do_capture_s) begin
                rf_wr_data_r <= 32'(switches);
            end else begin
                rf_wr_data_r <= rf_wr_data_r;
            end
        end
    end

    assign stall         = stall_s;
    assign rf_wr_en      = (state_r == WRITEBACK);
    assign rf_wr_sel     = A0_IDX;
    assign rf_wr_data    = rf_wr_data_r;
    assign display_value = display_value_r;
    assign display_valid = display_valid_r;
    assign halted        = (state_r == HALT);

endmodule
